regfile_dec: RTL and testbench

Parametrised register file built around an internal enable-gated one-hot write-address decoder, generalising the fixed 5-to-32 enabled decoder into a complete storage block. Provides one synchronous write port and two asynchronous read ports. The top-index register is optionally hardwired to zero. This is the CPU datapath register file and sits between instruction decode and the ALU.

---
 rtl/regfile_dec.sv | 85 ++++++++
 tb/tb_regfile_dec.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dec.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : regfile_dec
// Description : Register file with enable-gated one-hot write decoder, one
//               synchronous write port, two combinational read ports and an
//               optionally hardwired-zero top register. Optional same-cycle
//               write-to-read forwarding under macro REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dec #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 64,
    parameter int ZERO_TOP = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic [DATA_W-1:0]        rd_data1,
    output logic [DATA_W-1:0]        rd_data2,
    output logic [(2**ADDR_W)-1:0]   wr_sel
);

    localparam int                c_nreg     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_top_addr = ADDR_W'(c_nreg - 1);
    localparam logic              c_zero_top = (ZERO_TOP != 0);

    logic [DATA_W-1:0] w_regs [c_nreg];

    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < c_nreg; k++) begin
            wr_sel[k] = wr_en && (wr_addr == ADDR_W'(k));
        end
    end

    // The zeroed register has no storage at all; its slot is a constant.
    generate
        for (genvar k = 0; k < c_nreg; k++) begin : g_reg
            if (c_zero_top && (k == c_nreg - 1)) begin : g_zero
                assign w_regs[k] = '0;
            end else begin : g_live
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_q <= '0;
                    end else if (wr_sel[k]) begin
                        r_q <= wr_data;
                    end
                end
                assign w_regs[k] = r_q;
            end
        end
    endgenerate

    always_comb begin
        rd_data1 = w_regs[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (reset_n && wr_en && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
`endif
        if (c_zero_top && (rd_addr1 == c_top_addr)) begin
            rd_data1 = '0;
        end
    end

    always_comb begin
        rd_data2 = w_regs[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        if (reset_n && wr_en && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
        end
`endif
        if (c_zero_top && (rd_addr2 == c_top_addr)) begin
            rd_data2 = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dec.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_regfile_dec
// Description : Self-checking bench for regfile_dec (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dec;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [63:0] rd_data1;
    logic [63:0] rd_data2;
    logic [31:0] wr_sel;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] model [32];

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [63:0] e1;
        logic [63:0] e2;
    } rd_vec_t;

    rd_vec_t vecs [7];

    regfile_dec #(.ADDR_W(5), .DATA_W(64), .ZERO_TOP(1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_sel   (wr_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference read value derived from the register-file rules.
    function automatic logic [63:0] ref_read(input logic [4:0] a);
        logic [63:0] v;
        if (a == 5'd31 || !reset_n) begin
            v = 64'h0;
        end else begin
            v = model[a];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && a == wr_addr) v = wr_data;
`endif
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_sel();
        logic [31:0] s;
        s = 32'h0;
        if (wr_en) s[wr_addr] = 1'b1;
        return s;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        clear_model();

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd1", rd_data1, 64'h0);
        check("reset_rd2", rd_data2, 64'h0);
        check("reset_sel", 64'(wr_sel), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- async reset mid-cycle ----------------
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD_BEEF;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_addr1 = 5'd3; rd_addr2 = 5'd3;
        #1;
        check("wr3_rd1", rd_data1, 64'hDEAD_BEEF);
        reset_n = 1'b0;
        #1;
        check("async_reset_rd1", rd_data1, 64'h0);
        check("async_reset_rd2", rd_data2, 64'h0);
        // decoder stays live in reset, but a write under reset is dropped
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
        #1;
        check("sel_in_reset", 64'(wr_sel), 64'h200);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        reset_n = 1'b1;
        rd_addr1 = 5'd9;
        #1;
        check("write_in_reset_dropped", rd_data1, 64'h0);

        // ---------------- write all with decoder sweep ----------------
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 5'(k);
            wr_data = (k == 31) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h1000 + 64'(k);
            #1;
            check($sformatf("sel_en_%0d", k), 64'(wr_sel), 64'(32'd1 << k));
            @(posedge clk);
            if (k != 31) model[k] = wr_data;
        end

        // ---------------- decoder disabled sweep (no writes happen) ----------------
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            wr_en   = 1'b0;
            wr_addr = 5'(k);
            wr_data = 64'h55;
            #1;
            check($sformatf("sel_dis_%0d", k), 64'(wr_sel), 64'h0);
        end

        // ---------------- table-driven read checks ----------------
        vecs[0] = '{5'd0,  5'd0,  64'h1000, 64'h1000};
        vecs[1] = '{5'd3,  5'd30, 64'h1003, 64'h101E};
        vecs[2] = '{5'd31, 5'd31, 64'h0,    64'h0};
        vecs[3] = '{5'd30, 5'd5,  64'h101E, 64'h1005};
        vecs[4] = '{5'd7,  5'd7,  64'h1007, 64'h1007};
        vecs[5] = '{5'd16, 5'd15, 64'h1010, 64'h100F};
        vecs[6] = '{5'd1,  5'd31, 64'h1001, 64'h0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rd_addr1 = vecs[i].a1;
            rd_addr2 = vecs[i].a2;
            #1;
            check($sformatf("vec%0d_rd1", i), rd_data1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), rd_data2, vecs[i].e2);
        end

        // ---------------- same-cycle read during write ----------------
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hA;
        @(posedge clk);
        model[5] = 64'hA;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hB;
        rd_addr1 = 5'd5; rd_addr2 = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before_edge", rd_data1, 64'hB);
`else
        check("rdw_before_edge", rd_data1, 64'hA);
`endif
        check("rdw_other_port", rd_data2, 64'h1004);
        @(posedge clk);
        model[5] = 64'hB;
        #1;
        wr_en = 1'b0;
        #1;
        check("rdw_after_edge", rd_data1, 64'hB);

        // zero register never forwards
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h1234; rd_addr2 = 5'd31;
        #1;
        check("zero_no_fwd", rd_data2, 64'h0);
        @(posedge clk);

        // ---------------- randomized against reference model ----------------
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            reset_n  = ($urandom_range(0, 24) != 0);
            wr_en    = 1'($urandom);
            wr_addr  = 5'($urandom);
            wr_data  = {$urandom, $urandom};
            rd_addr1 = 5'($urandom);
            rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            if (!reset_n) clear_model();
            #1;
            check("rnd_rd1", rd_data1, ref_read(rd_addr1));
            check("rnd_rd2", rd_data2, ref_read(rd_addr2));
            check("rnd_sel", 64'(wr_sel), 64'(ref_sel()));
            @(posedge clk);
            if (reset_n && wr_en && wr_addr != 5'd31) model[wr_addr] = wr_data;
        end

        @(negedge clk);
        reset_n = 1'b1;
        wr_en   = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
